// File: rtl/jtframe_sram_pkg.sv
// Shared types for the SRAM arbiter: sequencer states, wait-counter width, port ids.
// Pure declarations; no logic, latency or backpressure of its own.
package jtframe_sram_pkg;

    localparam int   CNT_W = 3;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_TURN
    } state_t;

endpackage

// File: rtl/jtframe_sram_grant.sv
// Request-to-grant selection, combinational; round-robin pointer only with JTFRAME_SRAM_RR_EN.
// Zero latency; take marks the cycle the sequencer consumes the grant.
module jtframe_sram_grant
    import jtframe_sram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt_vld,
    output logic gnt_sel
);

`ifdef JTFRAME_SRAM_RR_EN
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_sel = req1 ? PORT1 : PORT0;
        if (req0 && req1) gnt_sel = ptr_q;
        ptr_d = ptr_q;
        // Point away from whoever just won so a persistent requester cannot starve the other
        if (take && gnt_vld) ptr_d = ~gnt_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= PORT0;
        else     ptr_q <= ptr_d;
    end
`else
    logic unused_grant;
    assign unused_grant = &{1'b0, clk, rst, take};

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_sel = req0 ? PORT0 : PORT1;
    end
`endif

endmodule

// File: rtl/jtframe_sram_arb.sv
// Two-port arbiter/sequencer for an async 16-bit SRAM; JTFRAME_SRAM_RR_EN selects round-robin.
// ack one cycle after the request is sampled, dok WAIT+3 after; requester holds rd/wr until ack.
module jtframe_sram_arb
    import jtframe_sram_pkg::*;
#(
    parameter int AW   = 21,
    parameter int WAIT = 2,
    parameter int TURN = 1
)(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] p0_addr,
    input  logic          p0_wr,
    input  logic          p0_rd,
    input  logic [15:0]   p0_din,
    input  logic [1:0]    p0_dsn,
    output logic          p0_ack,
    output logic          p0_dok,
    output logic [15:0]   p0_dout,
    input  logic [AW-1:0] p1_addr,
    input  logic          p1_wr,
    input  logic          p1_rd,
    input  logic [15:0]   p1_din,
    input  logic [1:0]    p1_dsn,
    output logic          p1_ack,
    output logic          p1_dok,
    output logic [15:0]   p1_dout,
    output logic [AW-1:0] sram_addr,
    inout  wire  [15:0]   sram_data,
    output logic          sram_we,
    output logic          sram_oe,
    output logic          sram_ub,
    output logic          sram_lb
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    dsn;
        logic          wr;
    } req_t;

    localparam req_t REQ_RST = '{addr: '0, din: '0, dsn: 2'b11, wr: 1'b0};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    req_t             cur_q, cur_d;
    logic             we_q, we_d, oe_q, oe_d, doe_q, doe_d;
    logic [1:0]       ack_q, ack_d, dok_q, dok_d;
    logic [15:0]      dout0_q, dout0_d, dout1_q, dout1_d;

    logic             gnt_vld, gnt_sel, take, nxt_rd;
    req_t             p0_req, p1_req, gnt_req;

    assign p0_req  = '{addr: p0_addr, din: p0_din, dsn: p0_dsn, wr: p0_wr};
    assign p1_req  = '{addr: p1_addr, din: p1_din, dsn: p1_dsn, wr: p1_wr};
    assign gnt_req = gnt_sel ? p1_req : p0_req;
    assign take    = (state_q == S_IDLE) && gnt_vld;
    assign nxt_rd  = gnt_vld && !gnt_req.wr;

    jtframe_sram_grant u_grant (
        .clk     (clk),
        .rst     (rst),
        .req0    (p0_rd | p0_wr),
        .req1    (p1_rd | p1_wr),
        .take    (take),
        .gnt_vld (gnt_vld),
        .gnt_sel (gnt_sel)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        cur_d   = cur_q;
        we_d    = we_q;
        oe_d    = oe_q;
        doe_d   = doe_q;
        ack_d   = 2'b00;
        dok_d   = 2'b00;
        dout0_d = dout0_q;
        dout1_d = dout1_q;
        case (state_q)
            S_IDLE: if (gnt_vld) begin
                sel_d          = gnt_sel;
                cur_d          = gnt_req;
                ack_d[gnt_sel] = 1'b1;
                doe_d          = gnt_req.wr;
                state_d        = S_SETUP;
            end
            S_SETUP: begin
                cnt_d   = CNT_W'(WAIT - 1);
                we_d    = !cur_q.wr;
                oe_d    = cur_q.wr;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    we_d    = 1'b1;
                    oe_d    = 1'b1;
                    state_d = S_HOLD;
                    if (!cur_q.wr) begin
                        if (sel_q == PORT1) dout1_d = sram_data;
                        else                dout0_d = sram_data;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                dok_d[sel_q] = 1'b1;
                doe_d        = 1'b0;
                // Peek at the request IDLE will see: a read right behind a write needs turnaround
                if (cur_q.wr && nxt_rd && (TURN > 0)) begin
                    cnt_d   = CNT_W'(TURN - 1);
                    state_d = S_TURN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= PORT0;
            cur_q   <= REQ_RST;
            we_q    <= 1'b1;
            oe_q    <= 1'b1;
            doe_q   <= 1'b0;
            ack_q   <= 2'b00;
            dok_q   <= 2'b00;
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            cur_q   <= cur_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            doe_q   <= doe_d;
            ack_q   <= ack_d;
            dok_q   <= dok_d;
            dout0_q <= dout0_d;
            dout1_q <= dout1_d;
        end
    end

    assign sram_data = doe_q ? cur_q.din : {16{1'bz}};
    assign sram_addr = cur_q.addr;
    assign sram_ub   = cur_q.dsn[1];
    assign sram_lb   = cur_q.dsn[0];
    assign sram_we   = we_q;
    assign sram_oe   = oe_q;
    assign p0_ack    = ack_q[0];
    assign p1_ack    = ack_q[1];
    assign p0_dok    = dok_q[0];
    assign p1_dok    = dok_q[1];
    assign p0_dout   = dout0_q;
    assign p1_dout   = dout1_q;

    a_rd_wr_both: assert property (@(posedge clk) disable iff (rst)
        !(p0_rd && p0_wr) && !(p1_rd && p1_wr));

endmodule

// File: tb/tb_jtframe_sram_arb.sv
// Directed bench for jtframe_sram_arb with a behavioural async SRAM on the pins.
module tb_jtframe_sram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] p0_addr, p1_addr, sram_addr;
    logic        p0_wr, p0_rd, p1_wr, p1_rd;
    logic [15:0] p0_din, p1_din, p0_dout, p1_dout;
    logic [1:0]  p0_dsn, p1_dsn;
    logic        p0_ack, p0_dok, p1_ack, p1_dok;
    logic        sram_we, sram_oe, sram_ub, sram_lb;
    wire  [15:0] sram_data;
    logic [15:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jtframe_sram_arb dut (
        .clk(clk), .rst(rst),
        .p0_addr(p0_addr), .p0_wr(p0_wr), .p0_rd(p0_rd), .p0_din(p0_din), .p0_dsn(p0_dsn),
        .p0_ack(p0_ack), .p0_dok(p0_dok), .p0_dout(p0_dout),
        .p1_addr(p1_addr), .p1_wr(p1_wr), .p1_rd(p1_rd), .p1_din(p1_din), .p1_dsn(p1_dsn),
        .p1_ack(p1_ack), .p1_dok(p1_dok), .p1_dout(p1_dout),
        .sram_addr(sram_addr), .sram_data(sram_data), .sram_we(sram_we), .sram_oe(sram_oe),
        .sram_ub(sram_ub), .sram_lb(sram_lb)
    );

    assign sram_data = !sram_oe ? mem[sram_addr[7:0]] : {16{1'bz}};

    always @(posedge clk) begin
        if (!sram_we) begin
            if (!sram_lb) mem[sram_addr[7:0]][7:0]  <= sram_data[7:0];
            if (!sram_ub) mem[sram_addr[7:0]][15:8] <= sram_data[15:8];
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        p0_addr = '0; p0_wr = 0; p0_rd = 0; p0_din = '0; p0_dsn = 2'b11;
        p1_addr = '0; p1_wr = 0; p1_rd = 0; p1_din = '0; p1_dsn = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if ({sram_we, sram_oe, sram_ub, sram_lb} !== 4'b1111) begin
            bad++; $display("FAIL rst_ctrl we/oe/ub/lb=%b want 1111", {sram_we, sram_oe, sram_ub, sram_lb}); end
        total++; if (sram_addr !== 21'h0) begin
            bad++; $display("FAIL rst_addr got %h want 0", sram_addr); end
        total++; if (dut.doe_q !== 1'b0) begin
            bad++; $display("FAIL rst_bus drive=%b want 0", dut.doe_q); end
        total++; if ({p0_ack, p0_dok, p1_ack, p1_dok} !== 4'b0000) begin
            bad++; $display("FAIL rst_hs ack/dok=%b want 0000", {p0_ack, p0_dok, p1_ack, p1_dok}); end
        total++; if ({p0_dout, p1_dout} !== 32'h0) begin
            bad++; $display("FAIL rst_dout got %h want 0", {p0_dout, p1_dout}); end
    endtask

    task automatic test_single_write();
        int ack_c, dok_c, we_lo, dat_bad;
        logic drv_hold, drv_end;
        ack_c = 0; dok_c = 0; we_lo = 0; dat_bad = 0; drv_hold = 0; drv_end = 1;
        @(negedge clk);
        p0_addr = 21'h00123; p0_din = 16'hBEEF; p0_dsn = 2'b00; p0_wr = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (p0_ack && ack_c == 0) begin ack_c = c; p0_wr = 0; end
            if (p0_dok && dok_c == 0) dok_c = c;
            if (!sram_we) begin
                we_lo++;
                if (sram_data !== 16'hBEEF || sram_addr !== 21'h123 || sram_ub || sram_lb) dat_bad++;
            end
            if (c == 4) drv_hold = dut.doe_q;
            if (c == 8) drv_end = dut.doe_q;
        end
        total++; if (ack_c !== 1) begin bad++; $display("FAIL wr_ack_cycle got %0d want 1", ack_c); end
        total++; if (dok_c !== 5) begin bad++; $display("FAIL wr_dok_cycle got %0d want 5", dok_c); end
        total++; if (we_lo !== 2) begin bad++; $display("FAIL wr_we_low got %0d want 2", we_lo); end
        total++; if (dat_bad !== 0) begin bad++; $display("FAIL wr_bus_value bad_cycles=%0d want 0", dat_bad); end
        total++; if (drv_hold !== 1'b1) begin bad++; $display("FAIL wr_hold_drive got %b want 1", drv_hold); end
        total++; if (drv_end !== 1'b0) begin bad++; $display("FAIL wr_release got %b want 0", drv_end); end
        total++; if (p0_dout !== 16'h0) begin bad++; $display("FAIL wr_dout_kept got %h want 0", p0_dout); end
    endtask

    task automatic test_read_back();
        int ack_c, dok_c, oe_lo, we_lo, drv;
        logic [15:0] dat;
        ack_c = 0; dok_c = 0; oe_lo = 0; we_lo = 0; drv = 0; dat = '0;
        @(negedge clk);
        p1_addr = 21'h00123; p1_dsn = 2'b00; p1_rd = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (p1_ack && ack_c == 0) begin ack_c = c; p1_rd = 0; end
            if (p1_dok && dok_c == 0) begin dok_c = c; dat = p1_dout; end
            if (!sram_oe) oe_lo++;
            if (!sram_we) we_lo++;
            if (dut.doe_q) drv++;
        end
        total++; if (ack_c !== 1) begin bad++; $display("FAIL rd_ack_cycle got %0d want 1", ack_c); end
        total++; if (dok_c !== 5) begin bad++; $display("FAIL rd_dok_cycle got %0d want 5", dok_c); end
        total++; if (oe_lo !== 2) begin bad++; $display("FAIL rd_oe_low got %0d want 2", oe_lo); end
        total++; if (we_lo !== 0) begin bad++; $display("FAIL rd_we_low got %0d want 0", we_lo); end
        total++; if (drv !== 0) begin bad++; $display("FAIL rd_bus_driven cycles=%0d want 0", drv); end
        total++; if (dat !== 16'hBEEF) begin bad++; $display("FAIL rd_data got %h want beef", dat); end
        total++; if (p0_dout !== 16'h0) begin bad++; $display("FAIL rd_other_dout got %h want 0", p0_dout); end
    endtask

    task automatic test_contention();
        int n0, n1, ng, p1_ack_c;
        logic [3:0] gseq;
        n0 = 0; n1 = 0; ng = 0; p1_ack_c = 0; gseq = '0;
        @(negedge clk);
        p0_addr = 21'h00040; p0_din = 16'h1234; p0_dsn = 2'b00; p0_wr = 1;
        p1_addr = 21'h00123; p1_dsn = 2'b00; p1_rd = 1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (p0_ack) begin if (ng < 4) gseq[ng] = 1'b0; ng++; n0++; end
            if (p1_ack) begin if (ng < 4) gseq[ng] = 1'b1; ng++; n1++; if (p1_ack_c == 0) p1_ack_c = c; end
`ifdef JTFRAME_SRAM_RR_EN
            if (ng >= 4) begin p0_wr = 0; p1_rd = 0; end
`else
            if (n0 >= 4) p0_wr = 0;
            if (p1_ack) p1_rd = 0;
`endif
        end
`ifdef JTFRAME_SRAM_RR_EN
        total++; if (gseq !== 4'b1010) begin bad++; $display("FAIL cont_order got %b want 1010", gseq); end
        total++; if (n0 !== 2 || n1 !== 2) begin bad++; $display("FAIL cont_acks got %0d/%0d want 2/2", n0, n1); end
`else
        total++; if (gseq !== 4'b0000) begin bad++; $display("FAIL cont_order got %b want 0000", gseq); end
        total++; if (n0 !== 4 || n1 !== 1) begin bad++; $display("FAIL cont_acks got %0d/%0d want 4/1", n0, n1); end
        total++; if (p1_ack_c !== 22) begin bad++; $display("FAIL cont_p1_ack_cycle got %0d want 22", p1_ack_c); end
`endif
        total++; if (p1_dout !== 16'hBEEF) begin bad++; $display("FAIL cont_p1_data got %h want beef", p1_dout); end
        total++; if (mem[8'h40] !== 16'h1234) begin bad++; $display("FAIL cont_p0_store got %h want 1234", mem[8'h40]); end
    endtask

    task automatic test_turnaround();
        int p0_dok_c, p1_ack_c, p1_dok_c;
        logic [2:0] turn_bus;
        p0_dok_c = 0; p1_ack_c = 0; p1_dok_c = 0; turn_bus = 3'b111;
        @(negedge clk);
        p0_addr = 21'h00055; p0_din = 16'hA5A5; p0_dsn = 2'b00; p0_wr = 1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (p0_ack) begin p0_wr = 0; p1_addr = 21'h00055; p1_dsn = 2'b00; p1_rd = 1; end
            if (p1_ack && p1_ack_c == 0) begin p1_ack_c = c; p1_rd = 0; end
            if (p0_dok && p0_dok_c == 0) p0_dok_c = c;
            if (p1_dok && p1_dok_c == 0) p1_dok_c = c;
            if (c == 5) turn_bus = {dut.doe_q, sram_we, sram_oe};
        end
        total++; if (p0_dok_c !== 5) begin bad++; $display("FAIL ta_p0_dok got %0d want 5", p0_dok_c); end
        total++; if (turn_bus !== 3'b011) begin bad++; $display("FAIL ta_turn_bus drive/we/oe=%b want 011", turn_bus); end
        total++; if (p1_ack_c !== 7) begin bad++; $display("FAIL ta_p1_ack got %0d want 7", p1_ack_c); end
        total++; if (p1_dok_c !== 11) begin bad++; $display("FAIL ta_p1_dok got %0d want 11", p1_dok_c); end
        total++; if (p1_dout !== 16'hA5A5) begin bad++; $display("FAIL ta_p1_data got %h want a5a5", p1_dout); end
    endtask

    task automatic test_reset_mid();
        int doks, ack_c, dok_c;
        logic we_acc;
        logic [2:0] post;
        doks = 0; ack_c = 0; dok_c = 0; we_acc = 1; post = '0;
        @(negedge clk);
        p0_addr = 21'h00077; p0_din = 16'h1111; p0_dsn = 2'b00; p0_wr = 1;
        @(negedge clk);
        if (p0_ack) p0_wr = 0;
        @(negedge clk);
        we_acc = sram_we;
        rst = 1'b1;
        @(negedge clk);
        post = {sram_we, sram_oe, dut.doe_q};
        rst = 1'b0;
        p0_wr = 0;
        total++; if (we_acc !== 1'b0) begin bad++; $display("FAIL rm_we_in_access got %b want 0", we_acc); end
        total++; if (post !== 3'b110) begin bad++; $display("FAIL rm_after_rst we/oe/drive=%b want 110", post); end
        total++; if (p1_dout !== 16'h0) begin bad++; $display("FAIL rm_dout_cleared got %h want 0", p1_dout); end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (p0_dok || p1_dok) doks++;
        end
        total++; if (doks !== 0) begin bad++; $display("FAIL rm_no_dok got %0d want 0", doks); end
        p1_addr = 21'h00123; p1_dsn = 2'b00; p1_rd = 1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (p1_ack && ack_c == 0) begin ack_c = c; p1_rd = 0; end
            if (p1_dok && dok_c == 0) dok_c = c;
        end
        total++; if (ack_c !== 1 || dok_c !== 5) begin
            bad++; $display("FAIL rm_new_read ack/dok=%0d/%0d want 1/5", ack_c, dok_c); end
        total++; if (p1_dout !== 16'hBEEF) begin bad++; $display("FAIL rm_new_data got %h want beef", p1_dout); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_contention();
        test_turnaround();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
